mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 38 +++
 rtl/mem_lsu_align.sv | 54 +++++
 rtl/mem_lsu.sv | 124 ++++++++++++
 tb/tb_mem_lsu.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared funct3 width codes, FSM states and request checks for mem_lsu
package mem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_t;

    // Stores only have the signed width codes; the unsigned variants are load-only.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if ((f3 == F3_H) || (f3 == F3_HU)) begin
            bad = off[0];
        end else if (f3 == F3_W) begin
            bad = (off != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// rtl/mem_lsu_align.sv - little-endian load extraction/extension and store lane merge
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] lane;

    assign sh      = {offset, 3'b000};
    assign shifted = word >> sh;

    always_comb begin
        load_data = 32'd0;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = shifted;
            F3_BU:   load_data = {24'd0, shifted[7:0]};
            F3_HU:   load_data = {16'd0, shifted[15:0]};
            default: load_data = 32'd0;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the fetched word passes through.
    always_comb begin
        mask       = 32'd0;
        lane       = 32'd0;
        store_word = word;
        case (funct3)
            F3_B: begin
                mask       = 32'h0000_00FF << sh;
                lane       = {24'd0, wdata[7:0]} << sh;
                store_word = (word & ~mask) | lane;
            end
            F3_H: begin
                mask       = 32'h0000_FFFF << sh;
                lane       = {16'd0, wdata[15:0]} << sh;
                store_word = (word & ~mask) | lane;
            end
            F3_W:    store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - single-request load/store unit bridging CPU requests to a word-wide RAM
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int  profundidad = 1024,
    localparam int AW          = $clog2(profundidad)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] address,
    output logic [31:0]   write_data,
    output logic          MemWrite,
    output logic          MemRead,
    input  logic [31:0]   read_data
);

    lsu_state_t  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    logic        req_bad;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_bad = !funct3_legal(req_we, req_funct3)
                   || misaligned(req_funct3, req_addr[1:0])
                   || ((req_addr >> (AW + 2)) != 32'd0);

    mem_lsu_align u_align (
        .funct3     (f3_q),
        .offset     (off_q),
        .word       (read_data),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
            wdata_q    <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            address    <= '0;
            write_data <= 32'd0;
            MemWrite   <= 1'b0;
            MemRead    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                            state      <= ST_DONE;
                        end else begin
                            address <= req_addr[AW+1:2];
                            MemRead <= 1'b1;
                            // A full-word store needs no read-modify-write and commits right away.
                            if (req_we && (req_funct3 == F3_W)) begin
                                MemWrite   <= 1'b1;
                                write_data <= req_wdata;
                            end
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    MemRead <= 1'b0;
                    if (we_q && (f3_q != F3_W)) begin
                        MemWrite   <= 1'b1;
                        write_data <= store_word;
                        state      <= ST_WRITE;
                    end else begin
                        MemWrite   <= 1'b0;
                        address    <= '0;
                        write_data <= 32'd0;
                        resp_valid <= 1'b1;
                        resp_rdata <= we_q ? 32'd0 : load_data;
                        state      <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    MemWrite   <= 1'b0;
                    address    <= '0;
                    write_data <= 32'd0;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'd0;
                    state      <= ST_DONE;
                end
                default: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu with a behavioural word RAM
module tb_mem_lsu;

    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] address;
    logic [31:0]   write_data;
    logic          MemWrite;
    logic          MemRead;
    logic [31:0]   read_data;

    logic [31:0]   ram [0:DEPTH-1];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bd_data;

    int n_cmp;
    int n_bad;

    mem_lsu #(.profundidad(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .address    (address),
        .write_data (write_data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign read_data = ram[address];

    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (MemWrite) begin
            ram[address] <= write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] data);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = AW'(idx);
        bd_data = data;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_lat, input int exp_wr, input int exp_rd_cnt);
        int lat;
        int nwr;
        int nrd;
        logic [31:0] rd;
        logic er;
        @(negedge clk);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ".busy"}, 32'(req_ready), 32'd0);
        lat = 1;
        nwr = 0;
        nrd = 0;
        rd  = 32'hXXXX_XXXX;
        er  = 1'bx;
        for (int i = 0; i < 10; i++) begin
            if (MemWrite) nwr++;
            if (MemRead)  nrd++;
            if (resp_valid) begin
                rd = resp_rdata;
                er = resp_err;
                chk({tag, ".done_addr"}, 32'(address), 32'd0);
                chk({tag, ".done_memwr"}, 32'(MemWrite), 32'd0);
                break;
            end
            lat++;
            @(negedge clk);
        end
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".err"}, 32'(er), 32'(exp_err));
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".memwrite_cycles"}, 32'(nwr), 32'(exp_wr));
        chk({tag, ".memread_cycles"}, 32'(nrd), 32'(exp_rd_cnt));
        @(negedge clk);
        chk({tag, ".resp_drop"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        bd_we      = 1'b0;
        bd_addr    = '0;
        bd_data    = 32'd0;
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.err", 32'(resp_err), 32'd0);
        chk("rst.memread", 32'(MemRead), 32'd0);
        chk("rst.memwrite", 32'(MemWrite), 32'd0);
        chk("rst.address", 32'(address), 32'd0);
        chk("rst.wdata", write_data, 32'd0);
        reset = 1'b0;

        poke(3, 32'h8899_AABB);
        poke(5, 32'h1111_2222);

        run_req("lb_0d",  1'b0, 3'b000, 32'h0D, 32'h0, 32'hFFFF_FFAA, 1'b0, 2, 0, 1);
        run_req("lhu_0e", 1'b0, 3'b101, 32'h0E, 32'h0, 32'h0000_8899, 1'b0, 2, 0, 1);
        run_req("lh_0e",  1'b0, 3'b001, 32'h0E, 32'h0, 32'hFFFF_8899, 1'b0, 2, 0, 1);
        run_req("lbu_0c", 1'b0, 3'b100, 32'h0C, 32'h0, 32'h0000_00BB, 1'b0, 2, 0, 1);
        run_req("lw_0c",  1'b0, 3'b010, 32'h0C, 32'h0, 32'h8899_AABB, 1'b0, 2, 0, 1);

        run_req("sh_0e",  1'b1, 3'b001, 32'h0E, 32'h0000_1234, 32'h0, 1'b0, 3, 1, 1);
        chk("sh_0e.ram3", ram[3], 32'h1234_AABB);

        run_req("lw_06",  1'b0, 3'b010, 32'h06, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        chk("lw_06.ram1", ram[1], 32'h0000_0000);

        run_req("sw_oor", 1'b1, 3'b010, 32'(4 * DEPTH), 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 0, 0);
        chk("sw_oor.ram0", ram[0], 32'h0000_0000);

        run_req("sw_10",  1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1, 1);
        chk("sw_10.ram4", ram[4], 32'hCAFE_F00D);
        run_req("lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFCA, 1'b0, 2, 0, 1);

        run_req("sb_15",  1'b1, 3'b000, 32'h15, 32'h0000_0077, 32'h0, 1'b0, 3, 1, 1);
        chk("sb_15.ram5", ram[5], 32'h1111_7722);

        run_req("sbu_ill", 1'b1, 3'b100, 32'h14, 32'h0000_00FF, 32'h0, 1'b1, 1, 0, 0);
        chk("sbu_ill.ram5", ram[5], 32'h1111_7722);
        run_req("ld_f3_3", 1'b0, 3'b011, 32'h14, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        run_req("sh_odd",  1'b1, 3'b001, 32'h15, 32'h0000_ABCD, 32'h0, 1'b1, 1, 0, 0);
        chk("sh_odd.ram5", ram[5], 32'h1111_7722);

        // SB 0x55 @0x01 interrupted by reset during its WRITE cycle.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h01;
        req_wdata  = 32'h0000_0055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstw.in_write", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstw.memwrite", 32'(MemWrite), 32'd0);
        chk("rstw.memread", 32'(MemRead), 32'd0);
        chk("rstw.ready", 32'(req_ready), 32'd1);
        chk("rstw.address", 32'(address), 32'd0);
        chk("rstw.wdata", write_data, 32'd0);
        chk("rstw.resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstw.no_resp", 32'(resp_valid), 32'd0);
        end
        chk("rstw.ram0", ram[0], 32'h0000_0000);
        run_req("lw_0", 1'b0, 3'b010, 32'h00, 32'h0, 32'h0000_0000, 1'b0, 2, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
